// File: rtl/hazard_ctrl_mdu.sv
// Pipeline hazard controller with a latency-counted MDU scoreboard.
// Optional stall performance counters are built only when HAZARD_PERF_EN is defined.
module hazard_ctrl_mdu #(
    parameter int REG_AW  = 5,
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs_d,
    input  logic [REG_AW-1:0] rt_d,
    input  logic [REG_AW-1:0] rs_e,
    input  logic [REG_AW-1:0] rt_e,
    input  logic [REG_AW-1:0] writereg_e,
    input  logic [REG_AW-1:0] writereg_m,
    input  logic [REG_AW-1:0] writereg_w,
    input  logic              memtoreg_e,
    input  logic              memtoreg_m,
    input  logic              regwrite_e,
    input  logic              regwrite_m,
    input  logic              regwrite_w,
    input  logic              branch_d,
    input  logic              mdu_op_d,
    input  logic              mdu_start_e,
    input  logic [REG_AW-1:0] mdu_dst_e,
    input  logic              perf_clr,
    output logic              forwarda_d,
    output logic              forwardb_d,
    output logic [1:0]        forwarda_e,
    output logic [1:0]        forwardb_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_e,
    output logic              mdu_busy,
    output logic              mdu_wb,
    output logic [REG_AW-1:0] mdu_wb_reg,
    output logic [CNT_W-1:0]  lw_stall_cnt,
    output logic [CNT_W-1:0]  br_stall_cnt,
    output logic [CNT_W-1:0]  mdu_stall_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    localparam logic [3:0] LAT_M1  = 4'(MDU_LAT - 1);
    localparam bit         LAT_ONE = (MDU_LAT == 1);

    mdu_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [REG_AW-1:0] pend_q, pend_d;
    logic              lw_stall_s, br_stall_s, mdu_stall_s;

    // E-stage forward select: M has priority over W, never for register 0.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                           input logic [REG_AW-1:0] wr_m, input logic we_m,
                                           input logic [REG_AW-1:0] wr_w, input logic we_w);
        logic [1:0] sel;
        if (src != '0 && src == wr_m && we_m) begin
            sel = 2'b10;
        end else if (src != '0 && src == wr_w && we_w) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Combinational forwarding and stall decisions.
    always_comb begin
        forwarda_d  = (rs_d != '0) && (rs_d == writereg_m) && regwrite_m;
        forwardb_d  = (rt_d != '0) && (rt_d == writereg_m) && regwrite_m;
        forwarda_e  = fwd_sel(rs_e, writereg_m, regwrite_m, writereg_w, regwrite_w);
        forwardb_e  = fwd_sel(rt_e, writereg_m, regwrite_m, writereg_w, regwrite_w);
        lw_stall_s  = memtoreg_e && ((rt_e == rs_d) || (rt_e == rt_d));
        br_stall_s  = branch_d &&
                      ((regwrite_e && ((writereg_e == rs_d) || (writereg_e == rt_d))) ||
                       (memtoreg_m && ((writereg_m == rs_d) || (writereg_m == rt_d))));
        // DONE releases the stall: the write-back is visible to D in the same cycle.
        mdu_stall_s = (state_q == ST_BUSY) &&
                      (((pend_q != '0) && ((pend_q == rs_d) || (pend_q == rt_d))) || mdu_op_d);
        stall_d     = lw_stall_s || br_stall_s || mdu_stall_s;
        stall_f     = stall_d;
        flush_e     = stall_d;
    end

    // Scoreboard next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        case (state_q)
            ST_IDLE: begin
                if (mdu_start_e) begin
                    pend_d  = mdu_dst_e;
                    cnt_d   = LAT_M1;
                    state_d = LAT_ONE ? ST_DONE : ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
                pend_d  = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
                pend_d  = '0;
            end
        endcase
    end

    // Scoreboard state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    assign mdu_busy   = (state_q != ST_IDLE);
    assign mdu_wb     = (state_q == ST_DONE);
    assign mdu_wb_reg = (state_q == ST_DONE) ? pend_q : '0;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] lw_cnt_q, br_cnt_q, mdu_cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        logic [CNT_W-1:0] r;
        if (en && (v != '1)) begin
            r = v + CNT_W'(1);
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Saturating stall counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lw_cnt_q  <= '0;
            br_cnt_q  <= '0;
            mdu_cnt_q <= '0;
        end else if (perf_clr) begin
            lw_cnt_q  <= '0;
            br_cnt_q  <= '0;
            mdu_cnt_q <= '0;
        end else begin
            lw_cnt_q  <= sat_inc(lw_cnt_q, lw_stall_s);
            br_cnt_q  <= sat_inc(br_cnt_q, br_stall_s);
            mdu_cnt_q <= sat_inc(mdu_cnt_q, mdu_stall_s);
        end
    end

    assign lw_stall_cnt  = lw_cnt_q;
    assign br_stall_cnt  = br_cnt_q;
    assign mdu_stall_cnt = mdu_cnt_q;
`else
    logic unused_perf_s;
    assign unused_perf_s = perf_clr;
    assign lw_stall_cnt  = '0;
    assign br_stall_cnt  = '0;
    assign mdu_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_mdu.sv
// Randomised self-checking bench for hazard_ctrl_mdu against a cycle-indexed reference model.
module tb_hazard_ctrl_mdu;
    localparam int AW   = 5;
    localparam int LAT  = 4;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;
`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [AW-1:0] rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w, mdu_dst_e;
    logic          memtoreg_e, memtoreg_m, regwrite_e, regwrite_m, regwrite_w;
    logic          branch_d, mdu_op_d, mdu_start_e, perf_clr;
    logic          forwarda_d, forwardb_d, stall_f, stall_d, flush_e, mdu_busy, mdu_wb;
    logic [1:0]    forwarda_e, forwardb_e;
    logic [AW-1:0] mdu_wb_reg;
    logic [CW-1:0] lw_stall_cnt, br_stall_cnt, mdu_stall_cnt;

    hazard_ctrl_mdu #(.REG_AW(AW), .MDU_LAT(LAT), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
        .writereg_e(writereg_e), .writereg_m(writereg_m), .writereg_w(writereg_w),
        .memtoreg_e(memtoreg_e), .memtoreg_m(memtoreg_m),
        .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
        .branch_d(branch_d), .mdu_op_d(mdu_op_d), .mdu_start_e(mdu_start_e),
        .mdu_dst_e(mdu_dst_e), .perf_clr(perf_clr),
        .forwarda_d(forwarda_d), .forwardb_d(forwardb_d),
        .forwarda_e(forwarda_e), .forwardb_e(forwardb_e),
        .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
        .mdu_busy(mdu_busy), .mdu_wb(mdu_wb), .mdu_wb_reg(mdu_wb_reg),
        .lw_stall_cnt(lw_stall_cnt), .br_stall_cnt(br_stall_cnt), .mdu_stall_cnt(mdu_stall_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;
    // Reference model: an MDU op is an issue cycle; everything else follows from it.
    int cyc       = 0;
    int issue_cyc = -1;
    int pend_m    = 0;
    int lw_m = 0, br_m = 0, md_m = 0;

    task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int fwd_e(input int r);
        if (r != 0 && r == int'(writereg_m) && regwrite_m) return 2;
        if (r != 0 && r == int'(writereg_w) && regwrite_w) return 1;
        return 0;
    endfunction

    task automatic clear_inputs();
        rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0;
        writereg_e = '0; writereg_m = '0; writereg_w = '0; mdu_dst_e = '0;
        memtoreg_e = 1'b0; memtoreg_m = 1'b0;
        regwrite_e = 1'b0; regwrite_m = 1'b0; regwrite_w = 1'b0;
        branch_d = 1'b0; mdu_op_d = 1'b0; mdu_start_e = 1'b0; perf_clr = 1'b0;
        rst_n = 1'b1;
    endtask

    // One clock: check outputs mid-cycle, then advance the model at the edge.
    task automatic step();
        bit busy, window, wb, lw, br, md, sd;
        @(negedge clk);
        busy   = (issue_cyc >= 0) && (cyc > issue_cyc) && (cyc <= issue_cyc + LAT);
        window = (issue_cyc >= 0) && (cyc > issue_cyc) && (cyc <  issue_cyc + LAT);
        wb     = (issue_cyc >= 0) && (cyc == issue_cyc + LAT);
        lw = memtoreg_e && (rt_e == rs_d || rt_e == rt_d);
        br = branch_d && ((regwrite_e && (writereg_e == rs_d || writereg_e == rt_d)) ||
                          (memtoreg_m && (writereg_m == rs_d || writereg_m == rt_d)));
        md = window && ((pend_m != 0 && (pend_m == int'(rs_d) || pend_m == int'(rt_d))) || mdu_op_d);
        sd = lw || br || md;
        check_val("forwarda_d", forwarda_d, (rs_d != 0 && rs_d == writereg_m && regwrite_m));
        check_val("forwardb_d", forwardb_d, (rt_d != 0 && rt_d == writereg_m && regwrite_m));
        check_val("forwarda_e", forwarda_e, fwd_e(int'(rs_e)));
        check_val("forwardb_e", forwardb_e, fwd_e(int'(rt_e)));
        check_val("stall_d", stall_d, sd);
        check_val("stall_f", stall_f, sd);
        check_val("flush_e", flush_e, sd);
        check_val("mdu_busy", mdu_busy, busy);
        check_val("mdu_wb", mdu_wb, wb);
        if (wb) check_val("mdu_wb_reg", mdu_wb_reg, pend_m);
        check_val("lw_stall_cnt", lw_stall_cnt, PERF ? lw_m : 0);
        check_val("br_stall_cnt", br_stall_cnt, PERF ? br_m : 0);
        check_val("mdu_stall_cnt", mdu_stall_cnt, PERF ? md_m : 0);
        @(posedge clk);
        if (!rst_n) begin
            issue_cyc = -1; pend_m = 0; lw_m = 0; br_m = 0; md_m = 0;
        end else begin
            if (perf_clr) begin
                lw_m = 0; br_m = 0; md_m = 0;
            end else begin
                if (lw && lw_m < CMAX) lw_m++;
                if (br && br_m < CMAX) br_m++;
                if (md && md_m < CMAX) md_m++;
            end
            if (!busy && mdu_start_e) begin
                issue_cyc = cyc;
                pend_m    = int'(mdu_dst_e);
            end else if (issue_cyc >= 0 && cyc >= issue_cyc + LAT) begin
                issue_cyc = -1;
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        // Reset state, with a start request that must be dropped.
        mdu_start_e = 1'b1; mdu_dst_e = 5'd7;
        step();
        step();
        clear_inputs();
        // Forwarding: M wins over W; register 0 never forwards.
        rs_e = 5'd5; writereg_m = 5'd5; regwrite_m = 1'b1; writereg_w = 5'd5; regwrite_w = 1'b1;
        step();
        rs_e = 5'd0;
        step();
        clear_inputs();
        // Load-use stall.
        memtoreg_e = 1'b1; rt_e = 5'd8; rs_d = 5'd8;
        step();
        clear_inputs();
        // MDU dependency on register 9.
        mdu_start_e = 1'b1; mdu_dst_e = 5'd9;
        step();
        clear_inputs();
        rs_d = 5'd9;
        repeat (5) step();
        clear_inputs();
        // Structural hazard: second MDU op waits in D, issues once released.
        mdu_start_e = 1'b1; mdu_dst_e = 5'd3;
        step();
        clear_inputs();
        mdu_op_d = 1'b1;
        repeat (4) step();
        mdu_op_d = 1'b0; mdu_start_e = 1'b1; mdu_dst_e = 5'd4;
        step();
        clear_inputs();
        repeat (5) step();
        // Reset two cycles into an MDU op: no write-back may follow.
        mdu_start_e = 1'b1; mdu_dst_e = 5'd6;
        step();
        clear_inputs();
        step();
        rst_n = 1'b0;
        step();
        clear_inputs();
        repeat (6) step();
        // Branch stall held long enough to saturate, then cleared while it persists.
        branch_d = 1'b1; regwrite_e = 1'b1; writereg_e = 5'd2; rs_d = 5'd2;
        repeat (5) step();
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        step();
        clear_inputs();
        // Randomised traffic over a small register window to force collisions.
        for (int i = 0; i < 3000; i++) begin
            rs_d = AW'($urandom_range(0, 3)); rt_d = AW'($urandom_range(0, 3));
            rs_e = AW'($urandom_range(0, 3)); rt_e = AW'($urandom_range(0, 3));
            writereg_e = AW'($urandom_range(0, 3)); writereg_m = AW'($urandom_range(0, 3));
            writereg_w = AW'($urandom_range(0, 3)); mdu_dst_e = AW'($urandom_range(0, 3));
            memtoreg_e = ($urandom_range(0, 3) == 0); memtoreg_m = ($urandom_range(0, 3) == 0);
            regwrite_e = ($urandom_range(0, 1) == 0); regwrite_m = ($urandom_range(0, 1) == 0);
            regwrite_w = ($urandom_range(0, 1) == 0); branch_d = ($urandom_range(0, 3) == 0);
            mdu_op_d = ($urandom_range(0, 5) == 0); mdu_start_e = ($urandom_range(0, 4) == 0);
            perf_clr = ($urandom_range(0, 30) == 0); rst_n = ($urandom_range(0, 60) != 0);
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl_mdu.md
# hazard_ctrl_mdu

Parametrised next-generation hazard controller for the 5-stage pipeline. Keeps the combinational forwarding, load-use and branch-stall decisions of the existing hazard logic, and adds an internal multi-cycle multiply/divide unit (MDU) scoreboard. The scoreboard replaces the external `mult_done` handshake with a latency counter and per-destination dependency tracking, plus optional stall performance counters. It sits beside the datapath: inputs come from D/E/M/W register-address fields, outputs drive the F/D enables and the E flush.

## Interface
Parameters:
- `REG_AW`, 5: register address width; address 0 is the hard-wired zero register.
- `MDU_LAT`, 4: MDU latency in cycles from issue in E to result write-back; legal range 1..15.
- `CNT_W`, 16: width of each performance counter.

Ports:
- `clk`  in  1  sole clock; all state on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `rs_d`, `rt_d`, `rs_e`, `rt_e`  in  REG_AW  source registers in D and E.
- `writereg_e`, `writereg_m`, `writereg_w`  in  REG_AW  destination registers in E, M, W.
- `memtoreg_e`, `memtoreg_m`  in  1  load in E / M.
- `regwrite_e`, `regwrite_m`, `regwrite_w`  in  1  register write enable in E / M / W.
- `branch_d`  in  1  branch in D.
- `mdu_op_d`  in  1  D instruction is an MDU op.
- `mdu_start_e`  in  1  MDU op issuing from E this cycle.
- `mdu_dst_e`  in  REG_AW  MDU destination register.
- `perf_clr`  in  1  synchronous clear of the performance counters.
- `forwarda_d`, `forwardb_d`  out  1  D-stage forward from M.
- `forwarda_e`, `forwardb_e`  out  2  E-stage forward select: 10 = M, 01 = W, 00 = register file.
- `stall_f`, `stall_d`, `flush_e`  out  1  pipeline control.
- `mdu_busy`  out  1  scoreboard not IDLE.
- `mdu_wb`  out  1  one-cycle MDU result write-back strobe.
- `mdu_wb_reg`  out  REG_AW  write-back register; valid while `mdu_wb` is high.
- `lw_stall_cnt`, `br_stall_cnt`, `mdu_stall_cnt`  out  CNT_W  stall statistics.

## Operation
Forwarding (combinational):
- `forwarda_d = rs_d!=0 & rs_d==writereg_m & regwrite_m`; `forwardb_d` is the same with `rt_d`.
- For E, M has priority over W. Neither path fires for register 0.

Stall causes (combinational):
- lw: `memtoreg_e & (rt_e==rs_d | rt_e==rt_d)`.
- br: `branch_d & ((regwrite_e & writereg_e ∈ {rs_d, rt_d}) | (memtoreg_m & writereg_m ∈ {rs_d, rt_d}))`.
- mdu: `state==BUSY & ((pend!=0 & pend ∈ {rs_d, rt_d}) | mdu_op_d)`.
- `stall_d` is the OR of the three causes. `stall_f = stall_d`. `flush_e = stall_d`.

Scoreboard FSM (IDLE, BUSY, DONE):
- IDLE → BUSY when `mdu_start_e`. Capture `pend <= mdu_dst_e` and `cnt <= MDU_LAT-1`.
- IDLE → DONE directly when `MDU_LAT==1`.
- BUSY: `cnt` decrements each cycle. When `cnt==1`, go to DONE.
- DONE: lasts exactly one cycle. `mdu_wb=1` and `mdu_wb_reg=pend`. Next state is IDLE, and `pend` clears to 0.
- DONE releases all mdu stalls. The register file writes first-half, so D reads the result in the same cycle, and a queued MDU op may enter E next cycle.
- `mdu_start_e` in BUSY or DONE is a protocol violation and is ignored. It is unreachable while `mdu_op_d` stalling works.
- `mdu_busy` = state != IDLE.

Performance counters:
- Each counter increments by 1 in every cycle its cause is asserted; several counters may increment in the same cycle.
- Counters saturate at all-ones.
- `perf_clr` wins over a same-cycle increment.

## Timing
- Forwarding and stall outputs are combinational, with zero latency and no `#` delays.
- MDU issue at cycle t gives `mdu_wb` at cycle t+MDU_LAT.
- Dependent-instruction stall cycles equal MDU_LAT-1 when the dependent instruction sits in D at t+1.
- Reset (`rst_n=0` at a rising edge) forces: state IDLE, `cnt=0`, `pend=0`, `mdu_busy=0`, `mdu_wb=0`, `mdu_wb_reg=0`, all counters 0.
- Reset mid-operation aborts the MDU op; no `mdu_wb` is produced.
- An `mdu_start_e` in the same cycle as reset is dropped.

## Configuration
- `HAZARD_PERF_EN` defined: the three counters and `perf_clr` logic are built as above.
- `HAZARD_PERF_EN` undefined: the counter outputs are tied to 0, `perf_clr` is ignored, and no counter flops exist. The ports are present in both builds.

## Test plan
- Forwarding: `rs_e=5`, `writereg_m=5`, `regwrite_m=1`, `writereg_w=5`, `regwrite_w=1` → `forwarda_e=10`. With `rs_e=0` and the same M/W → `00`.
- Load-use: `memtoreg_e=1`, `rt_e=8`, `rs_d=8` → `stall_d=stall_f=flush_e=1` in that cycle. With `HAZARD_PERF_EN`, `lw_stall_cnt` goes 0→1.
- MDU dependency, MDU_LAT=4: `mdu_start_e`, `mdu_dst_e=9` at t, then `rs_d=9` from t+1 → stall high t+1..t+3, `mdu_wb=1` with `mdu_wb_reg=9` at t+4, stall low at t+4, `mdu_busy` low at t+5.
- Structural: second MDU op held in D (`mdu_op_d=1`) during BUSY → stalled until DONE. Its issue at t+5 → next `mdu_wb` at t+9.
- Reset at t+2 of an MDU op → `mdu_busy=0` at t+3 and no `mdu_wb` ever.
- Saturation with CNT_W=2: hold a branch stall for 5 cycles → `br_stall_cnt=3`. Assert `perf_clr` while the stall persists → 0 next cycle.
